// File: rtl/nf10_axis_arb_pkg.sv
// Shared types and constants for the nf10 AXI4-Stream round-robin arbiter.
// The index width is sized for the largest supported fan-in (4 inputs).
package nf10_axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_MAX_INPUTS  = 4;
  localparam int ARB_IDX_WIDTH   = $clog2(ARB_MAX_INPUTS);
  localparam int ARB_DATA_WIDTH  = 64;
  localparam int ARB_TUSER_WIDTH = 128;
  localparam int ARB_CNT_WIDTH   = 32;

  // Index that sits 'step' places after 'idx' on a ring of 'n' inputs.
  function automatic logic [ARB_IDX_WIDTH-1:0] rr_next(
    input logic [ARB_IDX_WIDTH-1:0] idx,
    input int                       n,
    input int                       step
  );
    int sum;
    sum = int'(idx) + step;
    return ARB_IDX_WIDTH'(sum % n);
  endfunction

endpackage

// File: rtl/nf10_rr_pick.sv
// Combinational round-robin picker: returns the first requesting input
// found scanning upward from the one after last_idx, with wrap-around.
module nf10_rr_pick
  import nf10_axis_arb_pkg::*;
#(
  parameter int C_NUM_INPUTS = 4
) (
  input  logic [C_NUM_INPUTS-1:0]  req,
  input  logic [ARB_IDX_WIDTH-1:0] last_idx,
  output logic [ARB_IDX_WIDTH-1:0] idx,
  output logic                     found
);

  logic [ARB_IDX_WIDTH-1:0] cand;

  // Walk from lowest to highest priority so the nearest requester wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = C_NUM_INPUTS; k >= 1; k--) begin
      cand = rr_next(last_idx, C_NUM_INPUTS, k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nf10_axis_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream master among
// up to four sources; a grant is held from the first beat through tlast.
module nf10_axis_rr_arbiter
  import nf10_axis_arb_pkg::*;
#(
  parameter int C_NUM_INPUTS       = 4,
  parameter int C_AXIS_DATA_WIDTH  = ARB_DATA_WIDTH,
  parameter int C_AXIS_TUSER_WIDTH = ARB_TUSER_WIDTH,
  parameter int C_CNT_WIDTH        = ARB_CNT_WIDTH
) (
  input  logic                                         aclk,
  input  logic                                         areset,
  input  logic                                         en,
  input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_NUM_INPUTS-1:0]                      s_axis_tvalid,
  input  logic [C_NUM_INPUTS-1:0]                      s_axis_tlast,
  output logic [C_NUM_INPUTS-1:0]                      s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]               m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
  output logic                                         m_axis_tvalid,
  output logic                                         m_axis_tlast,
  input  logic                                         m_axis_tready,
  output logic                                         busy,
  output logic [C_NUM_INPUTS-1:0]                      grant,
  output logic [C_NUM_INPUTS*C_CNT_WIDTH-1:0]          pkt_count
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int CW = C_CNT_WIDTH;
  localparam int IW = ARB_IDX_WIDTH;

  arb_state_t            state;
  arb_state_t            state_next;
  logic [IW-1:0]         grant_idx;
  logic [IW-1:0]         last_idx;
  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic [C_NUM_INPUTS-1:0] grant_q;
  logic                  start;
  logic                  xfer_last;

  nf10_rr_pick #(
    .C_NUM_INPUTS (C_NUM_INPUTS)
  ) u_pick (
    .req      (s_axis_tvalid),
    .last_idx (last_idx),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  // Zero-latency datapath: the granted input drives m_axis while BUSY,
  // everything is held at zero while IDLE.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == BUSY) begin
      for (int i = 0; i < C_NUM_INPUTS; i++) begin
        if (grant_idx == IW'(i)) begin
          m_axis_tdata     = s_axis_tdata[i*DW +: DW];
          m_axis_tstrb     = s_axis_tstrb[i*SW +: SW];
          m_axis_tuser     = s_axis_tuser[i*UW +: UW];
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tlast     = s_axis_tlast[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign start     = (state == IDLE) && en && pick_found;
  assign xfer_last = (state == BUSY) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = BUSY;
      BUSY:    if (xfer_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // last_idx resets to the top input so input 0 is first in line.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant_idx <= '0;
      last_idx  <= IW'(C_NUM_INPUTS - 1);
      grant_q   <= '0;
    end else if (start) begin
      grant_idx <= pick_idx;
      grant_q   <= {{(C_NUM_INPUTS-1){1'b0}}, 1'b1} << pick_idx;
    end else if (xfer_last) begin
      last_idx  <= grant_idx;
      grant_q   <= '0;
    end
  end

  for (genvar i = 0; i < C_NUM_INPUTS; i++) begin : g_cnt
    logic [CW-1:0] cnt;

    always_ff @(posedge aclk or posedge areset) begin
      if (areset)                                   cnt <= '0;
      else if (xfer_last && grant_idx == IW'(i))    cnt <= cnt + CW'(1);
    end

    assign pkt_count[i*CW +: CW] = cnt;
  end

  assign busy  = (state == BUSY);
  assign grant = grant_q;

endmodule

// File: tb/tb_nf10_axis_rr_arbiter.sv
// Randomized directed-phase bench for nf10_axis_rr_arbiter, checked each
// cycle against a packet-level round-robin model of the arbiter.
module tb_nf10_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int UW = 128;
  localparam int CW = 4;

  logic              aclk = 1'b0;
  logic              areset;
  logic              en;
  logic [N*DW-1:0]   s_tdata;
  logic [N*SW-1:0]   s_tstrb;
  logic [N*UW-1:0]   s_tuser;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic [SW-1:0]     m_tstrb;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic              busy;
  logic [N-1:0]      grant;
  logic [N*CW-1:0]   pkt_count;

  nf10_axis_rr_arbiter #(
    .C_NUM_INPUTS       (N),
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .C_CNT_WIDTH        (CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .en            (en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .busy          (busy),
    .grant         (grant),
    .pkt_count     (pkt_count)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Source side: packets waiting, current beat, length and hold flag.
  int pkts_left [N];
  int beat      [N];
  int len       [N];
  int plen_cfg  [N];
  bit offering  [N];
  int vpct;
  int rpct;
  bit rdy_toggle;
  int cyc;

  // Reference: who owns the output, who was served last, packets per input.
  bit mdl_busy;
  int mdl_gnt;
  int mdl_last;
  int mdl_cnt [N];

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic queue_pkts(input int i, input int n, input int l);
    pkts_left[i] += n;
    plen_cfg[i]   = l;
  endtask

  task automatic model_reset();
    mdl_busy = 1'b0;
    mdl_gnt  = 0;
    mdl_last = N - 1;
    for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
  endtask

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      if (!offering[i]) begin
        if (pkts_left[i] > 0 && $urandom_range(99) < vpct) begin
          if (beat[i] == 0) len[i] = (plen_cfg[i] > 0) ? plen_cfg[i] : int'($urandom_range(1, 8));
          offering[i] = 1'b1;
          s_tlast[i]  = (beat[i] == len[i] - 1);
        end else begin
          s_tlast[i]  = 1'b0;
        end
        s_tdata[i*DW +: DW] = {$urandom(), 32'(beat[i])};
        s_tstrb[i*SW +: SW] = 8'($urandom());
        s_tuser[i*UW +: UW] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      s_tvalid[i] = offering[i];
    end
    m_tready = rdy_toggle ? cyc[0] : ($urandom_range(99) < rpct);
  endtask

  task automatic compare_all();
    logic [N-1:0]    eg, er;
    logic            ev, el;
    logic [DW-1:0]   ed;
    logic [SW-1:0]   es;
    logic [UW-1:0]   eu;
    logic [N*CW-1:0] ec;
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0; es = '0; eu = '0;
    if (mdl_busy) begin
      eg[mdl_gnt] = 1'b1;
      er[mdl_gnt] = m_tready;
      ev = s_tvalid[mdl_gnt];
      el = s_tlast[mdl_gnt];
      ed = s_tdata[mdl_gnt*DW +: DW];
      es = s_tstrb[mdl_gnt*SW +: SW];
      eu = s_tuser[mdl_gnt*UW +: UW];
    end
    for (int i = 0; i < N; i++) ec[i*CW +: CW] = CW'(mdl_cnt[i] % (1 << CW));
    checkOutput("busy", 128'(busy), 128'(mdl_busy));
    checkOutput("grant", 128'(grant), 128'(eg));
    checkOutput("s_tready", 128'(s_tready), 128'(er));
    checkOutput("m_tvalid", 128'(m_tvalid), 128'(ev));
    checkOutput("m_tlast", 128'(m_tlast), 128'(el));
    checkOutput("m_tdata", 128'(m_tdata), 128'(ed));
    checkOutput("m_tstrb", 128'(m_tstrb), 128'(es));
    checkOutput("m_tuser", m_tuser, eu);
    checkOutput("pkt_count", 128'(pkt_count), 128'(ec));
  endtask

  // Advance sources and model by one clock edge using the rules of the arbiter.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (offering[i] && mdl_busy && mdl_gnt == i && m_tready) begin
        offering[i] = 1'b0;
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          pkts_left[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    if (!mdl_busy) begin
      if (en && (s_tvalid != '0)) begin
        for (int k = N; k >= 1; k--)
          if (s_tvalid[(mdl_last + k) % N]) mdl_gnt = (mdl_last + k) % N;
        mdl_busy = 1'b1;
      end
    end else if (s_tvalid[mdl_gnt] && m_tready && s_tlast[mdl_gnt]) begin
      mdl_cnt[mdl_gnt]++;
      mdl_last = mdl_gnt;
      mdl_busy = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      drive_sources();
      #4;
      compare_all();
      model_step();
      @(posedge aclk);
      #1;
      cyc++;
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic reset_mid_cycle();
    areset = 1'b1;
    #1;
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_grant", 128'(grant), 128'(0));
    checkOutput("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    checkOutput("rst_m_tdata", 128'(m_tdata), 128'(0));
    checkOutput("rst_s_tready", 128'(s_tready), 128'(0));
    checkOutput("rst_pkt_count", 128'(pkt_count), 128'(0));
    model_reset();
    for (int i = 0; i < N; i++) begin
      offering[i] = 1'b0;
      beat[i]     = 0;
    end
    s_tvalid = '0;
    s_tlast  = '0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    areset = 1'b1; en = 1'b0; m_tready = 1'b0;
    s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = '0; s_tlast = '0;
    vpct = 100; rpct = 100; rdy_toggle = 1'b0; cyc = 0;
    for (int i = 0; i < N; i++) begin
      pkts_left[i] = 0; beat[i] = 0; len[i] = 1; plen_cfg[i] = 0; offering[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge aclk);
    #4;
    compare_all();
    @(posedge aclk);
    #1;
    areset = 1'b0;

    $display("[TB] single source, 16-beat packet");
    en = 1'b1;
    queue_pkts(0, 1, 16);
    applyStimulus(20);
    checkOutput("single_count0", 128'(pkt_count[CW-1:0]), 128'(1));

    $display("[TB] four sources, 4-beat packets");
    for (int i = 0; i < N; i++) queue_pkts(i, 2, 4);
    applyStimulus(45);
    checkOutput("four_counts", 128'(pkt_count), 128'(16'h2223));

    $display("[TB] enable gating");
    en = 1'b0;
    queue_pkts(1, 1, 6);
    queue_pkts(2, 1, 6);
    applyStimulus(5);
    checkOutput("en_off_busy", 128'(busy), 128'(0));
    en = 1'b1;
    applyStimulus(1);
    checkOutput("en_on_grant", 128'(grant), 128'(4'b0010));
    applyStimulus(3);
    en = 1'b0;
    applyStimulus(12);
    checkOutput("en_drop_busy", 128'(busy), 128'(0));
    checkOutput("en_drop_count1", 128'(pkt_count[CW +: CW]), 128'(3));

    $display("[TB] backpressure toggle");
    en = 1'b1;
    rdy_toggle = 1'b1;
    queue_pkts(0, 1, 5);
    queue_pkts(3, 1, 5);
    applyStimulus(60);
    rdy_toggle = 1'b0;

    $display("[TB] single-beat source against continuous source, counter wrap");
    queue_pkts(0, 20, 2);
    queue_pkts(3, 20, 1);
    applyStimulus(140);

    $display("[TB] reset mid-packet");
    queue_pkts(0, 1, 16);
    applyStimulus(7);
    reset_mid_cycle();
    queue_pkts(1, 1, 3);
    applyStimulus(1);
    checkOutput("post_rst_grant", 128'(grant), 128'(4'b0001));
    applyStimulus(30);

    $display("[TB] randomized traffic");
    vpct = 60;
    rpct = 70;
    for (int i = 0; i < N; i++) plen_cfg[i] = 0;
    repeat (20) begin
      en = ($urandom_range(99) < 80);
      queue_pkts(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 3)), 0);
      applyStimulus(50);
    end
    en = 1'b1;
    vpct = 100;
    rpct = 100;
    applyStimulus(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nf10_axis_rr_arbiter.md
# nf10_axis_rr_arbiter

Packet-granular round-robin arbiter that shares one 64-bit AXI4-Stream master port between up to four stream sources, such as several nf10_axis_gen_check generators feeding a single loopback or MAC port. A grant is locked from the first beat to tlast, so packets never interleave. Per-input packet counters and a global enable support loopback test sequencing.

## Interface
Parameters:
- C_NUM_INPUTS, 4: number of slave stream inputs, legal range 2..4.
- C_AXIS_DATA_WIDTH, 64: tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128: tuser width.
- C_CNT_WIDTH, 32: width of each per-input packet counter.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset. This is fixed: one clock; reset is asynchronous and active-high.
- en  in  1  when high, new grants are allowed; when low, no new packet starts.
- s_axis_tdata  in  N*64  flattened per-input data; input i occupies bits [i*64 +: 64].
- s_axis_tstrb  in  N*8  flattened per-input byte strobes.
- s_axis_tuser  in  N*128  flattened per-input sideband.
- s_axis_tvalid  in  N  per-input valid.
- s_axis_tlast  in  N  per-input end of packet.
- s_axis_tready  out  N  per-input ready.
- m_axis_tdata  out  64  output data.
- m_axis_tstrb  out  8  output byte strobes.
- m_axis_tuser  out  128  output sideband.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high while in BUSY.
- grant  out  N  one-hot granted input; all zero when idle.
- pkt_count  out  N*C_CNT_WIDTH  flattened count of packets forwarded from each input.

## Operation
- The FSM has two states: IDLE and BUSY. Registered state: state, grant_idx, last_idx, and the counters.
- Reset values:
  - state = IDLE, last_idx = N-1 (so input 0 has first priority), grant = 0, pkt_count = 0.
  - All m_axis_* outputs are 0, all s_axis_tready bits are 0, busy = 0.
- IDLE:
  - All outputs are held at zero.
  - If en=1 and any s_axis_tvalid bit is set, select the first valid input scanning from (last_idx+1) mod N upward with wrap-around.
  - Register the selection into grant_idx and move to BUSY.
  - If en=0, stay in IDLE regardless of valids.
- BUSY:
  - m_axis_* is a combinational mux of input grant_idx.
  - s_axis_tready[grant_idx] = m_axis_tready; all other tready bits are 0.
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - On a transfer with tlast: increment pkt_count[grant_idx] (wraps modulo 2^C_CNT_WIDTH), set last_idx = grant_idx, return to IDLE.
  - If the granted input drops tvalid mid-packet, remain in BUSY and wait; m_axis_tvalid follows the input.
  - en=0 during BUSY has no effect; the current packet completes.
- Inputs that are not granted see tready=0 and must hold their data (standard AXIS rule). A not-granted input is never starved: at most N-1 packets are served before it.
- Reset asserted mid-packet: return to IDLE immediately and drop all outputs to 0. The partial packet is not counted, and upstream recovery is the source's responsibility.
- A single-beat packet (tvalid and tlast on the first beat) is legal and counts as one packet.

## Timing
- Arbitration takes 1 cycle: the grant is registered in IDLE and the first beat can appear on the cycle after entry to BUSY.
- At least one idle cycle separates back-to-back packets. Throughput for a 16-beat packet is therefore 16/17 beats per cycle.
- The datapath is zero-latency combinational from the granted input to m_axis. There is no data storage in the block.
- pkt_count, busy, and grant update on the clock edge following the tlast beat. grant and busy are registered outputs.

## Structure
- Package nf10_axis_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - the index width localparam, clog2 of C_NUM_INPUTS;
  - default width constants for data (64), tuser (128), and counter (32).
- Sub-module nf10_rr_pick is a purely combinational round-robin picker. Inputs are the request vector and last_idx; outputs are the index and a found flag. It is instantiated once.

## Test plan
- Single source: input 0 sends a 16-beat packet with tdata = beat index and tlast on beat 15, m_axis_tready=1.
  -> Output appears starting 1 cycle after tvalid rises, all 16 beats identical to input, pkt_count[0]=1, grant=4'b0001 during the packet.
- All four inputs valid continuously with 4-beat packets.
  -> Grant order 0,1,2,3,0, each packet contiguous, one idle cycle between packets, each count = 2 after 8 packets.
- Backpressure: m_axis_tready toggles 1,0,1,0 during a granted packet.
  -> Granted tready mirrors it, beats are neither lost nor duplicated, and non-granted tready stays 0.
- Enable gating: en=0 with inputs 1 and 2 valid.
  -> Stay IDLE, busy=0. Set en=1 -> input 1 is granted. Drop en mid-packet -> the packet completes, then no new grant.
- Wrap and starvation: input 3 sends 1-beat packets while input 0 is continuously valid.
  -> Grants alternate 3,0,3,0. Preload the counter near 2^32-1 (or use a small C_CNT_WIDTH=4) -> the counter wraps to 0.
- Reset mid-packet: assert areset on beat 5 of 16.
  -> All outputs are 0 within the same cycle, pkt_count is 0, and after release input 0 is granted first.
